// File: rtl/alu_seq_ctrl.sv
// Byte-serial ALU: accepts {command, A, B} frames over a valid/ready input
// and returns one or two result bytes over a valid/ready output.
module alu_seq_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, OPA, OPB, EXEC, OUT0, OUT1} state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_CMP = 3'd4;

    state_t     state;
    logic [2:0] op;
    logic [1:0] mode;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [7:0] acc_hi;
    logic [7:0] acc_lo;
    logic [2:0] cnt;
    logic [7:0] res_hi;

    logic       is_long;
    logic [8:0] mul_sum;
    logic [7:0] mul_hi_next;
    logic [7:0] mul_lo_next;
    logic [8:0] div_shift;
    logic       div_ge;
    logic [8:0] div_diff;
    logic [7:0] div_rem_next;
    logic [7:0] div_q_next;
    logic [7:0] cmp_res;
    logic [7:0] short_res;
    logic       unused_cmd_bits;

    assign unused_cmd_bits = ^in_data[7:5];
    assign is_long = (op == OP_MUL) || (op == OP_DIV);

    // MUL: {acc_hi, acc_lo} holds {partial sum, remaining multiplier bits}.
    // DIV: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    always_comb begin
        mul_sum      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_reg} : 9'd0);
        mul_hi_next  = mul_sum[8:1];
        mul_lo_next  = {mul_sum[0], acc_lo[7:1]};
        div_shift    = {acc_hi, acc_lo[7]};
        div_ge       = div_shift >= {1'b0, b_reg};
        div_diff     = div_shift - {1'b0, b_reg};
        div_rem_next = div_ge ? div_diff[7:0] : div_shift[7:0];
        div_q_next   = {acc_lo[6:0], div_ge};
    end

    always_comb begin
        case (mode)
            2'b01:   cmp_res = (a_reg == b_reg) ? 8'h01 : 8'h00;
            2'b10:   cmp_res = (a_reg >  b_reg) ? 8'h01 : 8'h00;
            2'b11:   cmp_res = (a_reg <  b_reg) ? 8'h01 : 8'h00;
            default: cmp_res = 8'h01;
        endcase
        case (op)
            OP_ADD:  short_res = a_reg + b_reg;
            OP_SUB:  short_res = a_reg - b_reg;
            OP_CMP:  short_res = cmp_res;
            default: short_res = 8'hEE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= 3'd0;
            mode      <= 2'd0;
            a_reg     <= 8'h00;
            b_reg     <= 8'h00;
            acc_hi    <= 8'h00;
            acc_lo    <= 8'h00;
            cnt       <= 3'd0;
            res_hi    <= 8'h00;
            in_ready  <= 1'b1;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op    <= in_data[2:0];
                        mode  <= in_data[4:3];
                        busy  <= 1'b1;
                        state <= OPA;
                    end
                end
                OPA: begin
                    if (in_valid) begin
                        a_reg <= in_data;
                        state <= OPB;
                    end
                end
                OPB: begin
                    if (in_valid) begin
                        b_reg    <= in_data;
                        acc_hi   <= 8'h00;
                        acc_lo   <= (op == OP_MUL) ? in_data : a_reg;
                        cnt      <= 3'd0;
                        err      <= (op > OP_CMP);
                        in_ready <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_long) begin
                        cnt    <= cnt + 3'd1;
                        acc_hi <= (op == OP_MUL) ? mul_hi_next : div_rem_next;
                        acc_lo <= (op == OP_MUL) ? mul_lo_next : div_q_next;
                        if (cnt == 3'd7) begin
                            // Divide-by-zero runs the full 8 steps, then reports 0/0.
                            if (op == OP_MUL) begin
                                out_data <= mul_lo_next;
                                res_hi   <= mul_hi_next;
                            end else begin
                                out_data <= (b_reg == 8'h00) ? 8'h00 : div_q_next;
                                res_hi   <= (b_reg == 8'h00) ? 8'h00 : div_rem_next;
                            end
                            out_valid <= 1'b1;
                            state     <= OUT0;
                        end
                    end else begin
                        out_data  <= short_res;
                        out_valid <= 1'b1;
                        state     <= OUT0;
                    end
                end
                OUT0: begin
                    if (out_ready) begin
                        if (is_long) begin
                            out_data <= res_hi;
                            state    <= OUT1;
                        end else begin
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                OUT1: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: stimulus queues expected bytes and
// first-valid cycles; an independent monitor pops and compares them.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       err;

    alu_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [7:0] exp_q[$];
    int         lat_q[$];
    int         n_vec = 0;
    int         n_miss = 0;
    logic       ov_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor: first-valid timing and every output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !ov_prev) begin
                if (lat_q.size() == 0) flag("unexpected_out_valid");
                else chk("first_valid_cycle", cyc, lat_q.pop_front());
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) flag("unexpected_out_byte");
                else chk("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
            ov_prev = out_valid;
        end else begin
            ov_prev = 1'b0;
        end
    end

    // Called just after a negedge; returns after the negedge following the transfer.
    task automatic send_byte(input logic [7:0] d, output int hs_cyc);
        int  t;
        bit  acc;
        t = 0;
        acc = 1'b0;
        hs_cyc = cyc;
        in_data = d;
        in_valid = 1'b1;
        while (!acc && t < 100) begin
            acc = in_ready;
            hs_cyc = cyc;
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        if (!acc) flag("in_handshake_timeout");
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                         input int nbytes, input logic [7:0] b0, input logic [7:0] b1,
                         input int lat, input logic exp_err);
        int hc;
        exp_q.push_back(b0);
        if (nbytes == 2) exp_q.push_back(b1);
        send_byte(cmd, hc);
        send_byte(a, hc);
        send_byte(b, hc);
        lat_q.push_back(hc + lat);
        chk("err_in_exec", {31'd0, err}, {31'd0, exp_err});
        chk("busy_in_exec", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("err_after_exec", {31'd0, err}, 32'd0);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) flag("frame_timeout");
    endtask

    initial begin
        int hc;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;

        // cmd, A, B, bytes, byte0, byte1, cycles to first valid, err
        frame(8'h00, 8'hC8, 8'h64, 1, 8'h2C, 8'h00, 2, 1'b0); wait_done();
        frame(8'h02, 8'hFF, 8'hFF, 2, 8'h01, 8'hFE, 9, 1'b0); wait_done();
        frame(8'h01, 8'h03, 8'h05, 1, 8'hFE, 8'h00, 2, 1'b0); wait_done();
        frame(8'h03, 8'h64, 8'h07, 2, 8'h0E, 8'h02, 9, 1'b0); wait_done();
        frame(8'h03, 8'h64, 8'h00, 2, 8'h00, 8'h00, 9, 1'b0); wait_done();
        frame(8'h14, 8'h05, 8'h03, 1, 8'h01, 8'h00, 2, 1'b0); wait_done();
        frame(8'h1C, 8'h05, 8'h03, 1, 8'h00, 8'h00, 2, 1'b0); wait_done();
        frame(8'h0C, 8'h07, 8'h07, 1, 8'h01, 8'h00, 2, 1'b0); wait_done();
        frame(8'h04, 8'h05, 8'h03, 1, 8'h01, 8'h00, 2, 1'b0); wait_done();
        frame(8'h06, 8'h12, 8'h34, 1, 8'hEE, 8'h00, 2, 1'b1); wait_done();
        frame(8'hE0, 8'h80, 8'h80, 1, 8'h00, 8'h00, 2, 1'b0); wait_done();
        frame(8'h02, 8'h0D, 8'h0B, 2, 8'h8F, 8'h00, 9, 1'b0); wait_done();
        frame(8'h03, 8'hFF, 8'h10, 2, 8'h0F, 8'h0F, 9, 1'b0); wait_done();

        // Output stall on a MUL result, with stray in_valid that must be ignored.
        out_ready = 1'b0;
        frame(8'h02, 8'hFF, 8'hFF, 2, 8'h01, 8'hFE, 9, 1'b0);
        for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
        in_data = 8'hAA;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_out_data", {24'd0, out_data}, 32'h01);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_done();

        // Reset three cycles into MUL EXEC: the partial frame must vanish.
        send_byte(8'h02, hc);
        send_byte(8'h21, hc);
        send_byte(8'h43, hc);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("postrst_busy", {31'd0, busy}, 32'd0);
        frame(8'h00, 8'h01, 8'h01, 1, 8'h02, 8'h00, 2, 1'b0); wait_done();

        repeat (3) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
